fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 SHALL provide parameter ADDR_W, default 10, instruction memory word-address width.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  level; leaves IDLE, or resumes from HALT.
REQ-006 SHALL provide port halt_req  input  1  level; stops further fetches.
REQ-007 SHALL provide port redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL provide port redirect_pc  input  32  redirect byte target.
REQ-009 SHALL provide port mem_addr  output  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
REQ-010 SHALL provide port mem_data  input  32  combinational read data for mem_addr, same cycle.
REQ-011 SHALL provide port instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-012 SHALL provide port instr  output  32  registered instruction word.
REQ-013 SHALL provide port instr_pc  output  32  byte address of instr.
REQ-014 SHALL provide port instr_ready  input  1  downstream accepts when instr_valid && instr_ready.
REQ-015 SHALL provide port busy  output  1  high in FETCH or STALL.
REQ-016 SHALL provide port misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, STALL, HALT.
REQ-018 IDLE: start -> FETCH; redirect ignored; no loads.
REQ-019 FETCH: when !instr_valid or instr_ready, SHALL register instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (one-cycle latency address->output).
REQ-020 FETCH: instr_valid && !instr_ready -> STALL; outputs and pc held stable.
REQ-021 STALL: instr_ready -> FETCH; the accepting cycle SHALL also load the next word (no bubble).
REQ-022 halt_req in FETCH/STALL -> HALT; no new loads; a held valid instruction SHALL remain until accepted, then instr_valid<=0.
REQ-023 HALT: start && !halt_req -> FETCH, resuming at current pc; halt_req has priority over start.
REQ-024 redirect_valid in FETCH/STALL/HALT SHALL set pc<=redirect_pc with bits[1:0] forced 0, clear instr_valid next cycle (flush), and take priority over load; in STALL -> FETCH.
REQ-025 redirect_valid and halt_req together: redirect applied, state -> HALT.
REQ-026 redirect_valid and instr_ready together: held instruction counts as consumed and flushed.
REQ-027 pc SHALL increment modulo 2^32; mem_addr wraps from 1023 to 0 with no special handling.

Reset
REQ-028 reset SHALL force IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign_err=0, busy=0; overrides all other inputs, including mid-stall.

Configuration
REQ-029 With FETCH_MISALIGN_CHECK_EN defined, redirect with redirect_pc[1:0]!=0 SHALL leave pc unchanged, flush, set misalign_err=1 (cleared only by reset), enter HALT.
REQ-030 Without FETCH_MISALIGN_CHECK_EN, low bits SHALL be masked per REQ-024 and misalign_err SHALL be tied 0.

Structure
REQ-031 Shared package SHALL hold the state enum (IDLE, FETCH, STALL, HALT) and constant INSTR_W=32.
REQ-032 Single module; no sub-module required; memory stays external.

Verification
REQ-033 reset, start, ready=1, mem word i = i*0x11 -> instr_pc 0,4,8 on consecutive cycles, instr 0x00,0x11,0x22.
REQ-034 ready low 3 cycles at instr_pc=8 -> outputs held, state STALL, pc=12; ready high -> 12 next cycle, no bubble.
REQ-035 redirect to 0x100 during STALL -> instr_valid 0 for one cycle, then instr_pc=0x100, mem_addr=64.
REQ-036 pc=0xFFC -> mem_addr 1023 then 0; instr_pc 0x1000.
REQ-037 halt_req with held unaccepted instruction -> stays valid until ready, then 0; start resumes at saved pc.
REQ-038 macro defined, redirect to 0x102 -> misalign_err=1, state HALT, pc unchanged; undefined -> pc=0x100.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: FSM state encoding and instruction width shared by the fetch sequencer files
package fetch_sequencer_pkg;
  localparam int INSTR_W = 32;
  typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, instruction-memory and instruction-output bus of fetch_sequencer
//   master (sequencer): in  start, halt_req, redirect_valid, redirect_pc, mem_data, instr_ready
//                       out mem_addr, instr_valid, instr, instr_pc, busy, misalign_err
//   slave (environment): the same signals with directions reversed
interface fetch_sequencer_if #(parameter int ADDR_W = 10);
  import fetch_sequencer_pkg::*;
  logic               start;
  logic               halt_req;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [31:0]        instr_pc;
  logic               instr_ready;
  logic               busy;
  logic               misalign_err;
  modport master (
    input  start, halt_req, redirect_valid, redirect_pc, mem_data, instr_ready,
    output mem_addr, instr_valid, instr, instr_pc, busy, misalign_err
  );
  modport slave (
    output start, halt_req, redirect_valid, redirect_pc, mem_data, instr_ready,
    input  mem_addr, instr_valid, instr, instr_pc, busy, misalign_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer fetching one word per cycle from an external combinational memory
//   clk, reset (sync, active-high); bus = fetch_sequencer_if.master (control, memory, instruction output)
//   Define FETCH_MISALIGN_CHECK_EN to halt with a sticky misalign_err on redirects to non-word targets;
//   otherwise redirect targets have their low two bits masked and misalign_err stays 0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);
  localparam logic [1:0] S_IDLE = IDLE, S_FETCH = FETCH, S_STALL = STALL, S_HALT = HALT;
  logic [1:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d, ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d, err_q, err_d;
  logic               run, redir, bad, load, take;
  assign run   = state_q == S_FETCH || state_q == S_STALL;
  assign redir = bus.redirect_valid && state_q != S_IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad = redir && bus.redirect_pc[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif
  assign take = valid_q && bus.instr_ready;
  // STALL loads on the accepting cycle exactly like FETCH, so both share one load condition
  assign load = run && !redir && !bus.halt_req && (!valid_q || bus.instr_ready);
  always_comb begin
    pc_d    = bad ? pc_q : redir ? {bus.redirect_pc[31:2], 2'b00} : load ? pc_q + 32'd4 : pc_q;
    instr_d = load ? bus.mem_data : instr_q;
    ipc_d   = load ? pc_q : ipc_q;
    valid_d = load || (valid_q && !redir && !take);
    err_d   = err_q || bad;
    state_d = state_q == S_IDLE    ? (bus.start ? S_FETCH : S_IDLE) :
              (bad || bus.halt_req) ? S_HALT :
              run                  ? (valid_q && !bus.instr_ready && !redir ? S_STALL : S_FETCH) :
              bus.start            ? S_FETCH : S_HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign bus.mem_addr     = pc_q[ADDR_W+1:2];
  assign bus.instr_valid  = valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = ipc_q;
  assign bus.busy         = run;
  assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  fetch_sequencer_if #(.ADDR_W(10)) bus ();
  fetch_sequencer #(.RESET_PC(32'h0), .ADDR_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [1024];
  assign bus.mem_data = mem[bus.mem_addr];
  int checks = 0;
  int errors = 0;
  bit m_live = 1'b0, m_started, m_halted, m_valid, m_err;
  logic [31:0] m_pc, m_instr, m_ipc;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: started/halted flags, a PC counter and one output slot, driven by the input rules
  task automatic model_step();
    bit nh, hit;
    if (reset) begin
      m_live = 1'b1; m_started = 1'b0; m_halted = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      return;
    end
    if (!m_started) begin
      m_started = bus.start;
      return;
    end
    nh  = bus.halt_req ? 1'b1 : (m_halted && bus.start) ? 1'b0 : m_halted;
    hit = m_valid && bus.instr_ready;
    if (bus.redirect_valid) begin
      m_valid = 1'b0;
      if (MIS && bus.redirect_pc[1:0] != 2'b00) begin
        m_err = 1'b1;
        nh = 1'b1;
      end else m_pc = bus.redirect_pc & ~32'd3;
    end else if (!m_halted && !bus.halt_req && (!m_valid || hit)) begin
      m_instr = mem[m_pc[11:2]];
      m_ipc   = m_pc;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end else if (hit) m_valid = 1'b0;
    m_halted = nh;
  endtask

  task automatic cyc(bit r, bit s, bit h, bit rv, logic [31:0] rpc, bit rdy);
    reset = r; bus.start = s; bus.halt_req = h;
    bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.instr_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("busy", 32'(bus.busy), 32'(m_started && !m_halted));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_pc[11:2]));
      chk("misalign_err", 32'(bus.misalign_err), 32'(m_err));
      if (m_valid) begin
        chk("instr", bus.instr, m_instr);
        chk("instr_pc", bus.instr_pc, m_ipc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i * 32'h11;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    cyc(0, 0, 0, 1, 32'h40, 1);
    chk("idle_ignores_redirect", 32'(bus.mem_addr), 0);
    cyc(0, 1, 0, 0, 0, 1);
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_no_valid", 32'(bus.instr_valid), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("seq_instr_pc", bus.instr_pc, 32'(i * 4));
      chk("seq_instr", bus.instr, 32'(i * 32'h11));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("stall_instr_pc", bus.instr_pc, 32'h8);
      chk("stall_pc", 32'(bus.mem_addr), 3);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("unstall_instr_pc", bus.instr_pc, 32'hC);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h100, 0);
    chk("redir_flush", 32'(bus.instr_valid), 0);
    chk("redir_mem_addr", 32'(bus.mem_addr), 64);
    cyc(0, 0, 0, 0, 0, 1);
    chk("redir_instr_pc", bus.instr_pc, 32'h100);
    chk("redir_instr", bus.instr, 32'h440);
    cyc(0, 0, 0, 1, 32'hFFC, 1);
    chk("wrap_addr_top", 32'(bus.mem_addr), 1023);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_addr_zero", 32'(bus.mem_addr), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_instr_pc", bus.instr_pc, 32'h1000);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("halt_held_valid", 32'(bus.instr_valid), 1);
    chk("halt_not_busy", 32'(bus.busy), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("halt_still_held", bus.instr_pc, 32'h1000);
    cyc(0, 0, 1, 0, 0, 1);
    chk("halt_drained", 32'(bus.instr_valid), 0);
    cyc(0, 1, 0, 0, 0, 1);
    chk("resume_busy", 32'(bus.busy), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("resume_instr_pc", bus.instr_pc, 32'h1004);
    chk("resume_instr", bus.instr, 32'h11);
    cyc(0, 0, 0, 1, 32'h102, 1);
    chk("mis_mem_addr", 32'(bus.mem_addr), MIS ? 2 : 64);
    chk("mis_err", 32'(bus.misalign_err), 32'(MIS));
    chk("mis_busy", 32'(bus.busy), MIS ? 0 : 1);
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rpc;
      int sel;
      sel = int'($urandom_range(0, 3));
      rpc = sel == 0 ? 32'hFFFF_FFF8 : sel == 1 ? $urandom : ($urandom & 32'h0000_3FFC);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 11) == 0, rpc, $urandom_range(0, 9) < 7);
    end
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("rst_stall_valid", 32'(bus.instr_valid), 0);
    chk("rst_stall_busy", 32'(bus.busy), 0);
    chk("rst_stall_instr_pc", bus.instr_pc, 0);
    chk("rst_stall_mem_addr", 32'(bus.mem_addr), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
